// File: rtl/memory_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_unit_pkg
//  Description : Shared funct3 codes, FSM state encoding and access-size
//                helpers for the MEM-stage memory access unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package memory_access_unit_pkg;

    // RV32I load/store funct3 codes
    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    // Access FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Legal funct3 for the given direction (loads accept the unsigned forms)
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        logic ok;
        ok = (f3 == c_F3_LB) || (f3 == c_F3_LH) || (f3 == c_F3_LW);
        if (is_load)
            ok = ok || (f3 == c_F3_LBU) || (f3 == c_F3_LHU);
        return ok;
    endfunction

endpackage : memory_access_unit_pkg
`default_nettype wire

// File: rtl/memory_access_unit_load_store_align.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_unit_load_store_align
//  Description : Combinational lane logic: store byte-enable/data alignment,
//                load lane selection with sign/zero extension, and the
//                legal/aligned check for an incoming access.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_access_unit_load_store_align
    import memory_access_unit_pkg::*;
(
    // Store / check path (current EX/MEM access)
    input  logic        i_is_load,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_legal,
    // Load path (registered access attributes)
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_aligned;

    // Byte enables and replicated store data; loads always read the full word
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
        if (!i_is_load) begin
            case (i_funct3)
                c_F3_LB: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_store_data[7:0]}};
                end
                c_F3_LH: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_store_data[15:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_store_data;
                end
            endcase
        end
    end

    // Legal code and natural alignment for the access size (funct3[1:0])
    always_comb begin
        case (i_funct3[1:0])
            2'b01:   w_aligned = ~i_addr_lo[0];
            2'b10:   w_aligned = (i_addr_lo == 2'b00);
            default: w_aligned = 1'b1;
        endcase
        o_legal = f3_legal(i_is_load, i_funct3) && w_aligned;
    end

    // Pick the addressed lane of the read word and extend to 32 bits
    always_comb begin
        w_byte = i_rdata[8*i_ld_addr_lo +: 8];
        w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_ld_funct3)
            c_F3_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LBU: o_load_data = {24'd0, w_byte};
            c_F3_LH:  o_load_data = {{16{w_half[15]}}, w_half};
            c_F3_LHU: o_load_data = {16'd0, w_half};
            default:  o_load_data = i_rdata;
        endcase
    end

endmodule : memory_access_unit_load_store_align
`default_nettype wire

// File: rtl/memory_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_unit
//  Description : MEM-stage data-memory access unit. Issues one req/ack bus
//                transaction per load/store, stalls the pipeline until it
//                completes or times out, and registers formatted load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        em_mem_read_i,
    input  logic        em_mem_write_i,
    input  logic [2:0]  em_funct3_i,
    input  logic [31:0] em_alu_result_i,
    input  logic [31:0] em_read_data2_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int             CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_count;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [2:0]       r_funct3;
    logic [1:0]       r_addr_lo;
    logic [31:0]      r_load_data;
    logic             r_bus_err;

    logic             w_access;
    logic             w_both;
    logic             w_legal;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_fmt;
    logic             w_start;
    logic             w_ack_ok;
    logic             w_timeout;
    logic             w_stall;
    logic             w_misalign;

    assign w_access = em_mem_read_i ^ em_mem_write_i;
    assign w_both   = em_mem_read_i & em_mem_write_i;

    memory_access_unit_load_store_align u_align (
        .i_is_load    (em_mem_read_i),
        .i_funct3     (em_funct3_i),
        .i_addr_lo    (em_alu_result_i[1:0]),
        .i_store_data (em_read_data2_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_legal      (w_legal),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr_lo),
        .i_rdata      (dmem_rdata_i),
        .o_load_data  (w_load_fmt)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_i) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Next state, stall/misalign decode; reset asserted masks all actions
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_misalign   = 1'b0;
        w_start      = 1'b0;
        w_ack_ok     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_both) begin
                    w_misalign = 1'b1;
                end else if (w_access) begin
                    if (w_legal) begin
                        w_start      = 1'b1;
                        w_stall      = 1'b1;
                        w_next_state = S_BUSY;
                    end else begin
                        w_misalign = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                // Ack takes priority so an ack in the last allowed cycle wins
                if (dmem_ack_i) begin
                    w_ack_ok     = 1'b1;
                    w_next_state = S_DONE;
                end else if (r_count == c_CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (!reset_i) begin
            w_stall    = 1'b0;
            w_misalign = 1'b0;
            w_start    = 1'b0;
            w_ack_ok   = 1'b0;
            w_timeout  = 1'b0;
        end
    end

    // Bus request fields, timeout counter and result registers
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_count     <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_funct3    <= '0;
            r_addr_lo   <= '0;
            r_load_data <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if (w_start) begin
                r_count   <= '0;
                r_req     <= 1'b1;
                r_we      <= em_mem_write_i;
                r_addr    <= {em_alu_result_i[31:2], 2'b00};
                r_be      <= w_be;
                r_wdata   <= w_wdata;
                r_funct3  <= em_funct3_i;
                r_addr_lo <= em_alu_result_i[1:0];
            end else if (r_state == S_BUSY && r_count != c_CNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
            if (w_ack_ok) begin
                r_req <= 1'b0;
                if (!r_we) r_load_data <= w_load_fmt;
            end
            if (w_timeout) begin
                r_req       <= 1'b0;
                r_load_data <= '0;
            end
        end
    end

    assign dmem_req_o   = r_req;
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;
    assign stall_o      = w_stall;
    assign load_data_o  = r_load_data;
    assign misalign_o   = w_misalign;
    assign bus_err_o    = r_bus_err;

endmodule : memory_access_unit
`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_access_unit
//  Description : Directed self-checking bench for memory_access_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        em_mem_read_i;
    logic        em_mem_write_i;
    logic [2:0]  em_funct3_i;
    logic [31:0] em_alu_result_i;
    logic [31:0] em_read_data2_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        misalign_o;
    logic        bus_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    memory_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .em_mem_read_i   (em_mem_read_i),
        .em_mem_write_i  (em_mem_write_i),
        .em_funct3_i     (em_funct3_i),
        .em_alu_result_i (em_alu_result_i),
        .em_read_data2_i (em_read_data2_i),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_be_o       (dmem_be_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_ack_i      (dmem_ack_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .stall_o         (stall_o),
        .load_data_o     (load_data_o),
        .misalign_o      (misalign_o),
        .bus_err_o       (bus_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data);
        em_mem_read_i   = rd;
        em_mem_write_i  = wr;
        em_funct3_i     = f3;
        em_alu_result_i = addr;
        em_read_data2_i = data;
        #1;
    endtask

    task automatic clr_in();
        set_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    // Single-cycle-ack access: cycle 0 issue, cycle 1 ack, ends in DONE
    task automatic quick_access(input string tag, input logic rd, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] rdata);
        set_in(rd, ~rd, f3, addr, data);
        chk({tag, "_stall_c0"}, stall_o, 1);
        step();
        chk({tag, "_req_c1"}, dmem_req_o, 1);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
        #1;
        chk({tag, "_stall_c1"}, stall_o, 1);
        step();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'h0;
        #1;
        chk({tag, "_req_done"}, dmem_req_o, 0);
        chk({tag, "_stall_done"}, stall_o, 0);
    endtask

    initial begin
        reset_i      = 1'b0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'h0;
        clr_in();
        step();
        step();
        // Reset state
        chk("rst_req", dmem_req_o, 0);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_be", dmem_be_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_load", load_data_o, 0);
        chk("rst_mis", misalign_o, 0);
        chk("rst_err", bus_err_o, 0);
        reset_i = 1'b1;
        step();

        // 1. LW 0x100, ack on first request cycle
        set_in(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        chk("lw_stall_c0", stall_o, 1);
        chk("lw_req_c0", dmem_req_o, 0);
        step();
        chk("lw_req_c1", dmem_req_o, 1);
        chk("lw_we", dmem_we_o, 0);
        chk("lw_addr", dmem_addr_o, 32'h0000_0100);
        chk("lw_be", dmem_be_o, 4'b1111);
        chk("lw_stall_c1", stall_o, 1);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("lw_stall_ack", stall_o, 1);
        step();
        dmem_ack_i = 1'b0;
        #1;
        chk("lw_load_c2", load_data_o, 32'hDEAD_BEEF);
        chk("lw_req_c2", dmem_req_o, 0);
        chk("lw_stall_c2", stall_o, 0);
        step();
        chk("lw_no_reissue", stall_o, 1);   // back in IDLE with the same access still presented
        clr_in();
        chk("lw_idle_stall", stall_o, 0);
        step();

        // 2. SB 0x203 then LB 0x203
        set_in(1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5);
        step();
        chk("sb_addr", dmem_addr_o, 32'h0000_0200);
        chk("sb_be", dmem_be_o, 4'b1000);
        chk("sb_wdata", dmem_wdata_o, 32'hA5A5_A5A5);
        chk("sb_we", dmem_we_o, 1);
        dmem_ack_i = 1'b1;
        step();
        dmem_ack_i = 1'b0;
        #1;
        chk("sb_load_kept", load_data_o, 32'hDEAD_BEEF);
        clr_in();
        step();
        quick_access("lb", 1'b1, 3'b000, 32'h0000_0203, 32'h0, 32'h8000_0000);
        chk("lb_data", load_data_o, 32'hFFFF_FF80);
        clr_in();
        step();

        // SH 0x202: upper half lanes
        set_in(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
        step();
        chk("sh_be", dmem_be_o, 4'b1100);
        chk("sh_wdata", dmem_wdata_o, 32'hABCD_ABCD);
        dmem_ack_i = 1'b1;
        step();
        dmem_ack_i = 1'b0;
        clr_in();
        step();

        // 3. LHU / LH at 0x102
        quick_access("lhu", 1'b1, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_1234);
        chk("lhu_data", load_data_o, 32'h0000_8001);
        clr_in();
        step();
        quick_access("lh", 1'b1, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_1234);
        chk("lh_data", load_data_o, 32'hFFFF_8001);
        clr_in();
        step();

        // 4. SW 0x102 misaligned; illegal load funct3
        set_in(1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h1111_2222);
        chk("sw_mis", misalign_o, 1);
        chk("sw_mis_stall", stall_o, 0);
        step();
        chk("sw_mis_req", dmem_req_o, 0);
        clr_in();
        chk("sw_mis_clear", misalign_o, 0);
        set_in(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
        chk("ill_f3_mis", misalign_o, 1);
        step();
        chk("ill_f3_req", dmem_req_o, 0);
        clr_in();
        step();

        // Ack in the final (16th) BUSY cycle still succeeds
        set_in(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0);
        step();
        for (int i = 0; i < 15; i++) step();
        chk("last_ack_req", dmem_req_o, 1);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h1122_3344;
        step();
        dmem_ack_i = 1'b0;
        #1;
        chk("last_ack_err", bus_err_o, 0);
        chk("last_ack_data", load_data_o, 32'h1122_3344);
        clr_in();
        step();

        // 5. LW with ack withheld -> timeout after 16 BUSY cycles
        set_in(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        step();
        for (int i = 0; i < 16; i++) begin
            chk("to_req", dmem_req_o, 1);
            chk("to_err_low", bus_err_o, 0);
            step();
        end
        chk("to_err", bus_err_o, 1);
        chk("to_load", load_data_o, 32'h0);
        chk("to_req_drop", dmem_req_o, 0);
        chk("to_stall", stall_o, 0);
        clr_in();
        step();
        chk("to_err_pulse", bus_err_o, 0);
        chk("to_idle_stall", stall_o, 0);

        // 6. Reset while BUSY, late ack ignored, read+write both set
        quick_access("pre", 1'b1, 3'b010, 32'h0000_0108, 32'h0, 32'hCAFE_F00D);
        clr_in();
        step();
        set_in(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        step();
        chk("rb_req", dmem_req_o, 1);
        reset_i = 1'b0;
        #1;
        step();
        reset_i    = 1'b1;
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h5555_5555;
        clr_in();
        chk("rb_req_after", dmem_req_o, 0);
        chk("rb_stall_after", stall_o, 0);
        chk("rb_load_after", load_data_o, 32'h0);
        step();
        chk("late_ack_req", dmem_req_o, 0);
        chk("late_ack_load", load_data_o, 32'h0);
        dmem_ack_i = 1'b0;
        set_in(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0);
        chk("rdwr_mis", misalign_o, 1);
        chk("rdwr_stall", stall_o, 0);
        step();
        chk("rdwr_req", dmem_req_o, 0);
        clr_in();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_memory_access_unit
`default_nettype wire
